// File: rtl/cic_decimator_if.sv
// Sample-stream and PCM-output bundle for the CIC decimator.
// The bench drives through master; the filter consumes through slave.
interface cic_decimator_if;
    logic        din;
    logic        din_en;
    logic [23:0] Data_out;
    logic        dout_valid;

    modport master (
        output din,
        output din_en,
        input  Data_out,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_en,
        output Data_out,
        output dout_valid
    );
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC decimator for a 1-bit SDM stream.
// Parallel integrators feed a single time-shared comb subtractor.
module cic_decimator #(
    parameter int R = 64,
    parameter int N = 4,
    parameter int W = 2 + N * $clog2(R)
) (
    input  logic            clock,
    input  logic            rstn,
    cic_decimator_if.slave  io
);
    localparam int CW = $clog2(R);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int WU = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(R - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(N - 1);
    localparam logic [WU-1:0] WARM_DONE = WU'(N + 1);

    typedef enum logic [1:0] {IDLE, COMB, OUT} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  integ_q [N];
    logic [W-1:0]  integ_d [N];
    logic [W-1:0]  dly_q [N];
    logic [W-1:0]  dly_d [N];
    logic [W-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [WU-1:0] warm_q, warm_d;
    logic [23:0]   data_q, data_d;
    logic          valid_q, valid_d;

    logic [W-1:0]  x;
    logic [W-1:0]  diff;
    logic [W-1:0]  shifted;
    logic [23:0]   sat;
    logic          strobe;

    assign x       = {{(W-1){~io.din}}, 1'b1};
    assign strobe  = io.din_en && (cnt_q == CNT_LAST);
    assign diff    = c_q - dly_q[k_q];
    assign shifted = {c_q[W-1], c_q[W-1:1]};

    // Fits in 24 bits only when every bit above bit 23 matches the sign.
    always_comb begin
        sat = shifted[23:0];
        if (!(&shifted[W-1:23] || ~|shifted[W-1:23])) begin
            sat = shifted[W-1] ? 24'h800000 : 24'h7fffff;
        end
    end

    always_comb begin
        state_d = state_q;
        integ_d = integ_q;
        dly_d   = dly_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        warm_d  = warm_q;
        data_d  = data_q;
        valid_d = 1'b0;

        if (io.din_en) begin
            integ_d[0] = integ_q[0] + x;
            for (int j = 1; j < N; j++) begin
                integ_d[j] = integ_q[j] + integ_q[j-1];
            end
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    c_d     = integ_q[N-1];
                    k_d     = '0;
                    state_d = COMB;
                end
            end
            COMB: begin
                c_d        = diff;
                dly_d[k_q] = c_q;
                k_d        = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                data_d  = sat;
                valid_d = (warm_q == WARM_DONE);
                if (warm_q != WARM_DONE) begin
                    warm_d = warm_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            for (int j = 0; j < N; j++) begin
                integ_q[j] <= '0;
                dly_q[j]   <= '0;
            end
            c_q     <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            warm_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            integ_q <= integ_d;
            dly_q   <= dly_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            warm_q  <= warm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign io.Data_out   = data_q;
    assign io.dout_valid = valid_q;
endmodule
